// File: rtl/fifo_mc.sv
// Multi-channel synchronous FIFO: CHANNELS ring buffers share one memory addressed {ch, ptr}.
// One write and one read port with channel selects, registered per-channel status, sticky error flags.
module fifo_mc #(
  parameter int DWIDTH             = 64,
  parameter int AWIDTH             = 8,
  parameter int CHANNELS           = 4,
  parameter int ALMOST_FULL_VALUE  = 12,
  parameter int ALMOST_EMPTY_VALUE = 2,
  parameter bit REGISTER_OUTPUT    = 1'b1,
  localparam int CWIDTH            = $clog2(CHANNELS)
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic [DWIDTH-1:0]            data_i,
  input  logic                         wrreq_i,
  input  logic [CWIDTH-1:0]            wr_ch_i,
  input  logic                         rdreq_i,
  input  logic [CWIDTH-1:0]            rd_ch_i,
  output logic [DWIDTH-1:0]            q_o,
  output logic                         q_valid_o,
  output logic [CWIDTH-1:0]            q_ch_o,
  output logic [CHANNELS-1:0]          empty_o,
  output logic [CHANNELS-1:0]          full_o,
  output logic [CHANNELS*(AWIDTH+1)-1:0] usedw_o,
  output logic [CHANNELS-1:0]          almost_full_o,
  output logic [CHANNELS-1:0]          almost_empty_o,
  output logic [CHANNELS-1:0]          overflow_o,
  output logic [CHANNELS-1:0]          underflow_o
);
  localparam int   DEPTH  = 2 ** AWIDTH;
  localparam int   UW     = AWIDTH + 1;
  localparam int   MW     = CWIDTH + AWIDTH;
  localparam logic AF_RST = (ALMOST_FULL_VALUE <= 0);
  localparam logic AE_RST = (ALMOST_EMPTY_VALUE > 0);

  logic [DWIDTH-1:0]   mem [CHANNELS*DEPTH];
  logic [AWIDTH-1:0]   wr_ptr_q [CHANNELS];
  logic [AWIDTH-1:0]   wr_ptr_d [CHANNELS];
  logic [AWIDTH-1:0]   rd_ptr_q [CHANNELS];
  logic [AWIDTH-1:0]   rd_ptr_d [CHANNELS];
  logic [UW-1:0]       usedw_q  [CHANNELS];
  logic [UW-1:0]       usedw_d  [CHANNELS];
  logic [CHANNELS-1:0] empty_q, empty_d, full_q, full_d;
  logic [CHANNELS-1:0] afull_q, afull_d, aempty_q, aempty_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d, unf_q, unf_d;
  logic [CHANNELS-1:0] wr_hit, rd_hit, wr_ok, rd_ok;
  logic                wr_en, rd_en;
  logic [MW-1:0]       wr_addr, rd_addr;

  logic                rd_v1_q, rd_v1_d;
  logic [MW-1:0]       rd_a1_q, rd_a1_d;
  logic [CWIDTH-1:0]   rd_c1_q, rd_c1_d;
  logic                rd_v2_q, rd_v2_d;
  logic [DWIDTH-1:0]   rd_data2_q, rd_data2_d;
  logic [CWIDTH-1:0]   rd_c2_q, rd_c2_d;

  // Out-of-range channel selects never match a channel, so they have no effect at all.
  always_comb begin
    wr_hit  = '0;
    rd_hit  = '0;
    wr_ok   = '0;
    rd_ok   = '0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_hit[c] = wrreq_i && (wr_ch_i == CWIDTH'(c));
      rd_hit[c] = rdreq_i && (rd_ch_i == CWIDTH'(c));
      wr_ok[c]  = wr_hit[c] && !full_q[c];
      rd_ok[c]  = rd_hit[c] && !empty_q[c];
      if (wr_hit[c] && full_q[c])  ovf_d[c] = 1'b1;
      if (rd_hit[c] && empty_q[c]) unf_d[c] = 1'b1;
      if (wr_ok[c]) begin
        wr_en   = 1'b1;
        wr_addr = {CWIDTH'(c), wr_ptr_q[c]};
      end
      if (rd_ok[c]) begin
        rd_en   = 1'b1;
        rd_addr = {CWIDTH'(c), rd_ptr_q[c]};
      end
      wr_ptr_d[c] = wr_ptr_q[c] + AWIDTH'(wr_ok[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + AWIDTH'(rd_ok[c]);
      case ({wr_ok[c], rd_ok[c]})
        2'b10:   usedw_d[c] = usedw_q[c] + UW'(1);
        2'b01:   usedw_d[c] = usedw_q[c] - UW'(1);
        default: usedw_d[c] = usedw_q[c];
      endcase
      empty_d[c]  = (usedw_d[c] == '0);
      full_d[c]   = (usedw_d[c] == UW'(DEPTH));
      afull_d[c]  = (int'(usedw_d[c]) >= ALMOST_FULL_VALUE);
      aempty_d[c] = (int'(usedw_d[c]) < ALMOST_EMPTY_VALUE);
    end
  end

  // Address is registered first, then the memory read is registered; a write landing on the
  // same slot at that edge cannot disturb the read since it samples the old contents.
  always_comb begin
    rd_v1_d    = rd_en;
    rd_a1_d    = rd_en ? rd_addr : rd_a1_q;
    rd_c1_d    = rd_en ? rd_ch_i : rd_c1_q;
    rd_v2_d    = rd_v1_q;
    rd_data2_d = rd_v1_q ? mem[rd_a1_q] : rd_data2_q;
    rd_c2_d    = rd_v1_q ? rd_c1_q : rd_c2_q;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        usedw_q[c]  <= '0;
      end
      empty_q    <= '1;
      full_q     <= '0;
      afull_q    <= {CHANNELS{AF_RST}};
      aempty_q   <= {CHANNELS{AE_RST}};
      ovf_q      <= '0;
      unf_q      <= '0;
      rd_v1_q    <= 1'b0;
      rd_a1_q    <= '0;
      rd_c1_q    <= '0;
      rd_v2_q    <= 1'b0;
      rd_data2_q <= '0;
      rd_c2_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      usedw_q    <= usedw_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_v1_q    <= rd_v1_d;
      rd_a1_q    <= rd_a1_d;
      rd_c1_q    <= rd_c1_d;
      rd_v2_q    <= rd_v2_d;
      rd_data2_q <= rd_data2_d;
      rd_c2_q    <= rd_c2_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= data_i;
  end

  generate
    if (REGISTER_OUTPUT) begin : g_out_reg
      logic              q_valid_q, q_valid_d;
      logic [DWIDTH-1:0] q_q, q_d;
      logic [CWIDTH-1:0] q_ch_q, q_ch_d;

      always_comb begin
        q_valid_d = rd_v2_q;
        q_d       = rd_v2_q ? rd_data2_q : q_q;
        q_ch_d    = rd_v2_q ? rd_c2_q : q_ch_q;
      end

      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          q_valid_q <= 1'b0;
          q_q       <= '0;
          q_ch_q    <= '0;
        end else begin
          q_valid_q <= q_valid_d;
          q_q       <= q_d;
          q_ch_q    <= q_ch_d;
        end
      end

      assign q_o       = q_q;
      assign q_valid_o = q_valid_q;
      assign q_ch_o    = q_ch_q;
    end else begin : g_out_direct
      assign q_o       = rd_data2_q;
      assign q_valid_o = rd_v2_q;
      assign q_ch_o    = rd_c2_q;
    end
  endgenerate

  always_comb begin
    usedw_o = '0;
    for (int c = 0; c < CHANNELS; c++) usedw_o[c*UW +: UW] = usedw_q[c];
  end

  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule
